host_reset_monitor: RTL and testbench

- Receiving end of a reset line: watches the target machine's active-low RESET pin, which arrives asynchronously from the host bus.
- Synchronises it into fpga_clk and filters glitches with a minimum-assert qualifier and a release debounce.
- Reports host-reset state, one-cycle start/end events, the length of the last reset and a running reset count.
- Consumers are the ROM bank/config logic, which reloads on host reset, and debug readout.

---
 rtl/romulator_pkg.sv | 9 +
 rtl/bit_synchronizer.sv | 15 +
 rtl/host_reset_monitor.sv | 114 +++++++++++
 tb/tb_host_reset_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/romulator_pkg.sv
// romulator_pkg: shared FSM state type, counter widths and default qualifier lengths.
package romulator_pkg;
    typedef enum logic [1:0] {IDLE, QUALIFY, ASSERTED, RELEASING} hrm_state_t;
    localparam int RESET_COUNT_W        = 8;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_MIN_ASSERT_CLKS  = 16;
    localparam int DEF_MIN_RELEASE_CLKS = 4;
    localparam int DEF_LEN_WIDTH        = 24;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for an asynchronous level, resetting to 1.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain <= '1;
        else chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/host_reset_monitor.sv
// host_reset_monitor: synchronises and qualifies the host RESET pin, reporting state,
// start/end pulses, the length of the last reset and a running reset count.
module host_reset_monitor
    import romulator_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int MIN_ASSERT_CLKS  = DEF_MIN_ASSERT_CLKS,
    parameter int MIN_RELEASE_CLKS = DEF_MIN_RELEASE_CLKS,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH
) (
    input  logic                     fpga_clk,
    input  logic                     reset_n,
    input  logic                     host_reset_n,
    input  logic                     clear_count,
    output logic                     host_in_reset,
    output logic                     reset_start,
    output logic                     reset_end,
    output logic [LEN_WIDTH-1:0]     reset_len,
    output logic [RESET_COUNT_W-1:0] reset_count
);
    localparam int LW = $clog2(MIN_ASSERT_CLKS + 1);
    localparam int RW = $clog2(MIN_RELEASE_CLKS + 1);
    logic                     s;
    hrm_state_t               state;
    logic [LW-1:0]            lowcnt;
    logic [RW-1:0]            relcnt;
    logic [LEN_WIDTH-1:0]     len;
    logic [LEN_WIDTH-1:0]     len_inc;
    logic [RESET_COUNT_W-1:0] cnt_base;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (fpga_clk),
        .rst_n(reset_n),
        .d    (host_reset_n),
        .q    (s)
    );

    assign len_inc  = &len ? len : len + 1'b1;
    // A coincident clear wipes the old count before the new reset is counted.
    assign cnt_base = clear_count ? '0 : reset_count;

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            lowcnt        <= '0;
            relcnt        <= '0;
            len           <= '0;
            host_in_reset <= 1'b0;
            reset_start   <= 1'b0;
            reset_end     <= 1'b0;
            reset_len     <= '0;
            reset_count   <= '0;
        end else begin
            reset_start <= 1'b0;
            reset_end   <= 1'b0;
            reset_count <= cnt_base;
            case (state)
                IDLE: if (!s) begin
                    len    <= LEN_WIDTH'(1);
                    lowcnt <= LW'(1);
                    if (MIN_ASSERT_CLKS == 1) begin
                        state         <= ASSERTED;
                        host_in_reset <= 1'b1;
                        reset_start   <= 1'b1;
                        reset_count   <= cnt_base + 1'b1;
                    end else begin
                        state <= QUALIFY;
                    end
                end
                QUALIFY: if (s) begin
                    state <= IDLE;
                end else begin
                    lowcnt <= lowcnt + 1'b1;
                    len    <= len_inc;
                    if (lowcnt == LW'(MIN_ASSERT_CLKS - 1)) begin
                        state         <= ASSERTED;
                        host_in_reset <= 1'b1;
                        reset_start   <= 1'b1;
                        reset_count   <= cnt_base + 1'b1;
                    end
                end
                ASSERTED: begin
                    len <= len_inc;
                    if (s) begin
                        relcnt <= RW'(1);
                        if (MIN_RELEASE_CLKS == 1) begin
                            state         <= IDLE;
                            host_in_reset <= 1'b0;
                            reset_end     <= 1'b1;
                            reset_len     <= len_inc;
                        end else begin
                            state <= RELEASING;
                        end
                    end
                end
                RELEASING: begin
                    len <= len_inc;
                    if (!s) begin
                        state <= ASSERTED;
                    end else begin
                        relcnt <= relcnt + 1'b1;
                        if (relcnt == RW'(MIN_RELEASE_CLKS - 1)) begin
                            state         <= IDLE;
                            host_in_reset <= 1'b0;
                            reset_end     <= 1'b1;
                            reset_len     <= len_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_reset_monitor.sv
// tb_host_reset_monitor: two monitor configurations driven with directed host-pin patterns
// and checked every cycle against a run-length model plus literal expectations.
module tb_host_reset_monitor;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic host_reset_n = 1'b1;
    logic clear_count = 1'b0;
    logic inr1, st1, en1, inr2, st2, en2;
    logic [23:0] len1;
    logic [3:0]  len2;
    logic [7:0]  cnt1, cnt2;

    always #5 clk = ~clk;

    host_reset_monitor dut1 (
        .fpga_clk(clk), .reset_n(reset_n), .host_reset_n(host_reset_n), .clear_count(clear_count),
        .host_in_reset(inr1), .reset_start(st1), .reset_end(en1), .reset_len(len1), .reset_count(cnt1)
    );

    host_reset_monitor #(.SYNC_STAGES(3), .MIN_ASSERT_CLKS(1), .MIN_RELEASE_CLKS(4), .LEN_WIDTH(4)) dut2 (
        .fpga_clk(clk), .reset_n(reset_n), .host_reset_n(host_reset_n), .clear_count(clear_count),
        .host_in_reset(inr2), .reset_start(st2), .reset_end(en2), .reset_len(len2), .reset_count(cnt2)
    );

    logic o_inr[2], o_st[2], o_en[2];
    int   o_len[2], o_cnt[2];
    assign o_inr[0] = inr1;
    assign o_inr[1] = inr2;
    assign o_st[0]  = st1;
    assign o_st[1]  = st2;
    assign o_en[0]  = en1;
    assign o_en[1]  = en2;
    assign o_len[0] = int'(len1);
    assign o_len[1] = int'(len2);
    assign o_cnt[0] = int'(cnt1);
    assign o_cnt[1] = int'(cnt2);

    int checks = 0, errors = 0, cyc_n = 0;
    bit run = 1'b0;
    int sy[2]   = '{2, 3};
    int ma[2]   = '{16, 1};
    int mr[2]   = '{4, 4};
    int lmax[2] = '{16777215, 15};
    bit [15:0] hist[2];
    int low_run[2], high_run[2], mlen[2], m_rlen[2], m_cnt[2];
    bit m_inr[2], m_st[2], m_en[2];
    int n_st[2], n_en[2], n_inr, st_cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: delay the pin through a history word, then reason on run lengths of lows/highs.
    task automatic step(input int i);
        bit s;
        if (!reset_n) begin
            hist[i] = '1;
            low_run[i] = 0; high_run[i] = 0; mlen[i] = 0; m_rlen[i] = 0; m_cnt[i] = 0;
            m_inr[i] = 0; m_st[i] = 0; m_en[i] = 0;
        end else begin
            s = hist[i][sy[i]-1];
            hist[i] = {hist[i][14:0], host_reset_n};
            m_st[i] = 0;
            m_en[i] = 0;
            if (clear_count) m_cnt[i] = 0;
            if (!m_inr[i]) begin
                if (s) low_run[i] = 0;
                else begin
                    low_run[i]++;
                    mlen[i] = low_run[i] < lmax[i] ? low_run[i] : lmax[i];
                    if (low_run[i] == ma[i]) begin
                        m_st[i] = 1; m_inr[i] = 1; high_run[i] = 0;
                        m_cnt[i] = (m_cnt[i] + 1) % 256;
                    end
                end
            end else begin
                if (mlen[i] < lmax[i]) mlen[i]++;
                high_run[i] = s ? high_run[i] + 1 : 0;
                if (high_run[i] == mr[i]) begin
                    m_en[i] = 1; m_inr[i] = 0; m_rlen[i] = mlen[i]; low_run[i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc_n++;
        step(0);
        step(1);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.host_in_reset", i), int'(o_inr[i]), int'(m_inr[i]));
                chk($sformatf("dut%0d.reset_start", i), int'(o_st[i]), int'(m_st[i]));
                chk($sformatf("dut%0d.reset_end", i), int'(o_en[i]), int'(m_en[i]));
                chk($sformatf("dut%0d.reset_len", i), o_len[i], m_rlen[i]);
                chk($sformatf("dut%0d.reset_count", i), o_cnt[i], m_cnt[i]);
                if (o_st[i]) begin
                    n_st[i]++;
                    if (i == 0) st_cyc = cyc_n;
                end
                if (o_en[i]) n_en[i]++;
            end
            if (o_inr[0]) n_inr++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic one_reset();
        host_reset_n = 1'b0;
        cyc(20);
        host_reset_n = 1'b1;
        cyc(10);
    endtask

    initial begin
        int fall, s0, e0, i0;
        #2 reset_n = 1'b0;
        run = 1'b1;
        cyc(3);
        chk("rst.in_reset", int'(inr1), 0);
        chk("rst.len", int'(len1), 0);
        chk("rst.count", int'(cnt1), 0);
        chk("rst.dut2_count", int'(cnt2), 0);
        reset_n = 1'b1;
        cyc(2);

        fall = cyc_n;
        host_reset_n = 1'b0;
        cyc(100);
        host_reset_n = 1'b1;
        cyc(20);
        chk("t1.start_latency", st_cyc - fall, 18);
        chk("t1.starts", n_st[0], 1);
        chk("t1.ends", n_en[0], 1);
        chk("t1.reset_len", int'(len1), 104);
        chk("t1.count", int'(cnt1), 1);
        chk("t1.dut2_len_sat", int'(len2), 15);

        s0 = n_st[0]; e0 = n_en[0]; i0 = n_inr;
        host_reset_n = 1'b0;
        cyc(10);
        host_reset_n = 1'b1;
        cyc(20);
        chk("t2.no_start", n_st[0] - s0, 0);
        chk("t2.no_end", n_en[0] - e0, 0);
        chk("t2.no_in_reset", n_inr - i0, 0);
        chk("t2.count", int'(cnt1), 1);

        s0 = n_st[0]; e0 = n_en[0];
        host_reset_n = 1'b0;
        cyc(50);
        host_reset_n = 1'b1;
        cyc(2);
        host_reset_n = 1'b0;
        cyc(30);
        host_reset_n = 1'b1;
        cyc(20);
        chk("t3.one_start", n_st[0] - s0, 1);
        chk("t3.one_end", n_en[0] - e0, 1);
        chk("t3.reset_len", int'(len1), 86);
        chk("t3.count", int'(cnt1), 2);

        clear_count = 1'b1;
        cyc(1);
        clear_count = 1'b0;
        chk("t4.clear", int'(cnt1), 0);
        repeat (255) one_reset();
        chk("t4.count255", int'(cnt1), 255);
        one_reset();
        chk("t4.wrap", int'(cnt1), 0);
        host_reset_n = 1'b0;
        cyc(17);
        clear_count = 1'b1;
        cyc(1);
        clear_count = 1'b0;
        chk("t4.coincident_start", int'(st1), 1);
        chk("t4.coincident_count", int'(cnt1), 1);
        cyc(2);
        host_reset_n = 1'b1;
        cyc(10);

        host_reset_n = 1'b0;
        cyc(40);
        chk("t5.asserted", int'(inr1), 1);
        s0 = n_st[0]; e0 = n_en[0];
        reset_n = 1'b0;
        #1;
        chk("t5.imm_in_reset", int'(inr1), 0);
        chk("t5.imm_start", int'(st1), 0);
        chk("t5.imm_end", int'(en1), 0);
        chk("t5.imm_len", int'(len1), 0);
        chk("t5.imm_count", int'(cnt1), 0);
        chk("t5.imm_dut2", int'(inr2), 0);
        cyc(3);
        reset_n = 1'b1;
        cyc(25);
        chk("t5.fresh_start", n_st[0] - s0, 1);
        chk("t5.no_end", n_en[0] - e0, 0);
        chk("t5.in_reset", int'(inr1), 1);
        chk("t5.count", int'(cnt1), 1);
        host_reset_n = 1'b1;
        cyc(15);
        chk("t5.end", n_en[0] - e0, 1);
        chk("t5.reset_len", int'(len1), 29);

        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
